cv3_relu_maxpool: RTL and testbench

- Streaming stage directly downstream of the 4-channel 3x3 convolution column unit.
- Consumes one convolved FP16 column per valid_in pulse and buffers the first column of each column pair.
- Emits one 2x2 max-pooled column (with optional ReLU) for every two input columns.
- Tracks column position within a feature map so odd-width maps drop the trailing column cleanly.

---
 rtl/cv3_relu_maxpool.sv | 86 ++++++++
 tb/tb_cv3_relu_maxpool.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cv3_relu_maxpool.sv
// cv3_relu_maxpool: 2x2 max-pool over column pairs with optional ReLU (CV3_POOL_RELU_EN)
module cv3_relu_maxpool #(
  parameter int DATA_WIDTH = 16,
  parameter int INPUT_COL_SIZE = 10,
  parameter int IMAGE_COLS = 10,
  localparam int OUTPUT_COL_SIZE = INPUT_COL_SIZE / 2,
  localparam int IDX_W = $clog2(IMAGE_COLS / 2) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] input_column [INPUT_COL_SIZE],
  output logic [DATA_WIDTH-1:0] output_column [OUTPUT_COL_SIZE],
  output logic                  valid_out,
  output logic [IDX_W-1:0]      col_index,
  output logic                  frame_done
);
  localparam int CNT_W = $clog2(IMAGE_COLS);
  localparam int M = DATA_WIDTH - 1;
  typedef enum logic {EVEN, ODD} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_hold [INPUT_COL_SIZE];
  logic [DATA_WIDTH-1:0] w_in [INPUT_COL_SIZE];
  logic [DATA_WIDTH-1:0] w_pool [OUTPUT_COL_SIZE];
  logic w_last, w_fire;
  logic [IDX_W-1:0] w_idx;
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    return (a[M] != b[M]) ? (a[M] ? b : a) :
           a[M] ? ((a[M-1:0] <= b[M-1:0]) ? a : b) : ((a[M-1:0] >= b[M-1:0]) ? a : b);
  endfunction
  // optional ReLU on incoming elements, applied before they are held or pooled
  always_comb begin
    for (int i = 0; i < INPUT_COL_SIZE; i++)
`ifdef CV3_POOL_RELU_EN
      w_in[i] = input_column[i][M] ? '0 : input_column[i];
`else
      w_in[i] = input_column[i];
`endif
  end
  // 2x2 compare tree: held pair, then incoming pair, then across columns
  always_comb begin
    for (int r = 0; r < OUTPUT_COL_SIZE; r++)
      w_pool[r] = fmax(fmax(r_hold[2*r], r_hold[2*r+1]), fmax(w_in[2*r], w_in[2*r+1]));
  end
  // next state and column counter; the odd trailing column of a map is dropped in EVEN
  always_comb begin
    w_last = r_cnt == CNT_W'(IMAGE_COLS - 1);
    w_fire = valid_in && r_state == ODD;
    w_idx = IDX_W'(r_cnt >> 1);
    w_next = r_state;
    w_cnt_nxt = r_cnt;
    if (valid_in) begin
      w_next = (r_state == EVEN && !w_last) ? ODD : EVEN;
      w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
    end
  end
  // state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EVEN;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt_nxt;
    end
  end
  // hold buffer and registered pooled outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INPUT_COL_SIZE; i++) r_hold[i] <= '0;
      for (int r = 0; r < OUTPUT_COL_SIZE; r++) output_column[r] <= '0;
      valid_out <= 1'b0;
      col_index <= '0;
      frame_done <= 1'b0;
    end else begin
      if (valid_in && r_state == EVEN) r_hold <= w_in;
      if (w_fire) begin
        output_column <= w_pool;
        col_index <= w_idx;
      end
      valid_out <= w_fire;
      frame_done <= w_fire && w_idx == IDX_W'(IMAGE_COLS / 2 - 1);
    end
  end
endmodule

// File: tb/tb_cv3_relu_maxpool.sv
// tb_cv3_relu_maxpool: scoreboard bench for even (10) and odd (5) map widths
module tb_cv3_relu_maxpool;
  typedef struct packed {
    logic [4:0][15:0] d;
    logic [3:0] idx;
    logic fd;
    logic [31:0] due;
  } exp_t;
  logic clk = 0, rst = 1, valid_in = 0;
  logic [15:0] in_col [10];
  logic [15:0] out10 [5], out5 [5];
  logic vo10, vo5, fd10, fd5, pvo10 = 0, pvo5 = 0;
  logic [3:0] ci10;
  logic [1:0] ci5;
  int n_chk = 0, n_fail = 0, nvo10 = 0, nvo5 = 0;
  logic [31:0] cyc = 0;
  exp_t q0[$], q1[$];
  int mcnt[2];
  bit modd[2];
  logic [9:0][15:0] mhold[2];
  cv3_relu_maxpool #(.IMAGE_COLS(10)) u10 (.clk(clk), .rst(rst), .valid_in(valid_in), .input_column(in_col),
    .output_column(out10), .valid_out(vo10), .col_index(ci10), .frame_done(fd10));
  cv3_relu_maxpool #(.IMAGE_COLS(5)) u5 (.clk(clk), .rst(rst), .valid_in(valid_in), .input_column(in_col),
    .output_column(out5), .valid_out(vo5), .col_index(ci5), .frame_done(fd5));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int key(input logic [15:0] x);
    return x[15] ? -int'(x[14:0]) - 1 : int'(x[14:0]);
  endfunction
  function automatic logic [15:0] pick(input logic [15:0] a, input logic [15:0] b);
    return key(b) > key(a) ? b : a;
  endfunction
  function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef CV3_POOL_RELU_EN
    return x[15] ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction
  function automatic logic [9:0][15:0] rcol();
    logic [9:0][15:0] c;
    for (int i = 0; i < 10; i++) c[i] = 16'($urandom);
    return c;
  endfunction
  task automatic model(input int d, input logic [9:0][15:0] raw);
    int cols;
    logic [9:0][15:0] c;
    exp_t e;
    cols = d == 0 ? 10 : 5;
    for (int i = 0; i < 10; i++) c[i] = relu(raw[i]);
    if (!modd[d]) begin
      if (mcnt[d] == cols - 1) mcnt[d] = 0;
      else begin
        mhold[d] = c;
        modd[d] = 1;
        mcnt[d]++;
      end
    end else begin
      for (int r = 0; r < 5; r++)
        e.d[r] = pick(pick(pick(mhold[d][2*r], mhold[d][2*r+1]), c[2*r]), c[2*r+1]);
      e.idx = 4'(mcnt[d] >> 1);
      e.fd = (mcnt[d] >> 1) == cols / 2 - 1;
      e.due = cyc + 1;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      modd[d] = 0;
      mcnt[d] = mcnt[d] == cols - 1 ? 0 : mcnt[d] + 1;
    end
  endtask
  task automatic send(input logic [9:0][15:0] c, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
      valid_in = 0;
    end
    @(posedge clk); #1;
    valid_in = 1;
    for (int i = 0; i < 10; i++) in_col[i] = c[i];
    model(0, c);
    model(1, c);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 0;
    end
  endtask
  task automatic send_pair(input logic [15:0] h0, input logic [15:0] h1, input logic [15:0] i0, input logic [15:0] i1);
    logic [9:0][15:0] c;
    c = rcol(); c[0] = h0; c[1] = h1;
    send(c, 0);
    c = rcol(); c[0] = i0; c[1] = i1;
    send(c, 0);
    idle(1);
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    logic [4:0][15:0] g;
    if (!rst) begin
      if (vo10) begin
        nvo10++;
        check("b2b10", pvo10, 0);
        check("q10_has", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          for (int i = 0; i < 5; i++) g[i] = out10[i];
          check("data10", g, e.d);
          check("idx10", ci10, e.idx);
          check("fd10", fd10, e.fd);
          check("lat10", cyc, e.due);
        end
      end
      if (fd10) check("fd_vo10", vo10, 1);
      if (vo5) begin
        nvo5++;
        check("b2b5", pvo5, 0);
        check("q5_has", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          for (int i = 0; i < 5; i++) g[i] = out5[i];
          check("data5", g, e.d);
          check("idx5", {2'b00, ci5}, e.idx);
          check("fd5", fd5, e.fd);
          check("lat5", cyc, e.due);
        end
      end
      if (fd5) check("fd_vo5", vo5, 1);
    end
    pvo10 <= vo10;
    pvo5 <= vo5;
  end
  task automatic check_reset(input string tag);
    logic [4:0][15:0] g;
    for (int i = 0; i < 5; i++) g[i] = out10[i] | out5[i];
    check({tag, "_col"}, g, 0);
    check({tag, "_vo"}, {vo10, vo5}, 0);
    check({tag, "_ci"}, {ci10, ci5}, 0);
    check({tag, "_fd"}, {fd10, fd5}, 0);
  endtask
  initial begin
    for (int i = 0; i < 10; i++) in_col[i] = 0;
    mcnt = '{0, 0};
    modd = '{0, 0};
    #3;
    check_reset("rst0");
    @(posedge clk); #1;
    rst = 0;
    send_pair(16'h3C00, 16'h4000, 16'h3800, 16'h3E00);
    check("pos_vo", vo10, 1);
    check("pos_val", out10[0], 16'h4000);
    send_pair(16'hBC00, 16'hC000, 16'hBE00, 16'hC200);
    check("neg_vo", vo10, 1);
`ifdef CV3_POOL_RELU_EN
    check("neg_val", out10[0], 16'h0000);
`else
    check("neg_val", out10[0], 16'hBC00);
`endif
    send_pair(16'h0000, 16'h8000, 16'h8000, 16'h8000);
    check("zero_val", out10[0], 16'h0000);
    for (int k = 6; k < 10; k++) send(rcol(), 0);
    idle(2);
    @(negedge clk);
    check("nvo10_map1", nvo10, 5);
    check("nvo5_map1", nvo5, 4);
    for (int k = 0; k < 10; k++) send(rcol(), 0);
    for (int k = 0; k < 10; k++) send(rcol(), $urandom_range(0, 3));
    send(rcol(), 0);
    idle(3);
    #2;
    rst = 1;
    #1;
    check_reset("rst_mid");
    mcnt = '{0, 0};
    modd = '{0, 0};
    @(posedge clk); #1;
    rst = 0;
    send(rcol(), 1);
    send(rcol(), 2);
    idle(3);
    for (int t = 0; t < 50 && (q0.size() != 0 || q1.size() != 0); t++) @(posedge clk);
    check("drain", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
